afe_spi_multi: RTL and testbench

Parametrised write-only SPI engine for the analog front-end (AFE) attenuator/switch chains on the DSBPM carriers. It generalises the fixed two-channel AFE_SPI_CLK/SDI/LE pins to CHANNEL_COUNT independent buses. It adds programmable word length, a valid/ready command port, broadcast mode, error reporting and a done strobe. It sits in the sysClk domain between the CSR/GPIO command logic and the AFE_SPI_* top-level pins.

---
 rtl/afe_spi_multi_pkg.sv | 36 +++
 rtl/afe_spi_halfbit_timer.sv | 28 ++
 rtl/afe_spi_multi.sv | 164 ++++++++++++++++
 tb/tb_afe_spi_multi.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_spi_multi_pkg.sv
// rtl/afe_spi_multi_pkg.sv - shared state encoding and sizing helpers for the AFE SPI engine
package afe_spi_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_LATCH,
    ST_GAP
  } state_e;

  // Channel-select width; a single bus still gets a one-bit select port
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Bit-count width, wide enough to hold DATA_WIDTH itself
  function automatic int bc_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // Timer width, enough to hold the largest reload value (max(T, LE) - 1)
  function automatic int timer_width(input int clk_div, input int le_cycles);
    int m;
    m = (clk_div > le_cycles) ? clk_div : le_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Cycles cmdReady stays low for one n-bit write
  function automatic int busy_cycles(input int n, input int t, input int le);
    return 2 * n * t + 2 * t + le;
  endfunction

endpackage

// File: rtl/afe_spi_halfbit_timer.sv
// rtl/afe_spi_halfbit_timer.sv - reloadable down-counter pacing each FSM state
module afe_spi_halfbit_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Reload on state entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // A state loaded with value v therefore lasts exactly v+1 cycles
  assign tc = (count == '0);

endmodule

// File: rtl/afe_spi_multi.sv
// rtl/afe_spi_multi.sv - multi-bus write-only SPI engine for AFE attenuator/switch chains
module afe_spi_multi
  import afe_spi_multi_pkg::*;
#(
  parameter int CHANNEL_COUNT = 2,
  parameter int DATA_WIDTH    = 24,
  parameter int CLK_DIV       = 5,
  parameter int LE_CYCLES     = 10,
  parameter int CH_W          = ch_width(CHANNEL_COUNT),
  parameter int BC_W          = bc_width(DATA_WIDTH)
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CH_W-1:0]          cmdChannel,
  input  logic                     cmdBroadcast,
  input  logic [BC_W-1:0]          cmdBitCount,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic [CHANNEL_COUNT-1:0] spiClk,
  output logic [CHANNEL_COUNT-1:0] spiSdi,
  output logic [CHANNEL_COUNT-1:0] spiLe,
  output logic                     doneStrobe,
  output logic                     errorStrobe
);

  localparam int TMR_W = timer_width(CLK_DIV, LE_CYCLES);

  state_e                   state, state_next;
  logic [DATA_WIDTH-1:0]    shreg, shreg_next;
  logic [BC_W-1:0]          bits_left, bits_left_next;
  logic [CHANNEL_COUNT-1:0] mask, mask_next;

  logic                     cmd_ok;
  logic [BC_W-1:0]          cmd_shift;
  logic [DATA_WIDTH-1:0]    cmd_aligned;
  logic [CHANNEL_COUNT-1:0] cmd_mask;

  logic                     tmr_load;
  logic                     tmr_tc;
  logic [TMR_W-1:0]         tmr_value;

  logic [CHANNEL_COUNT-1:0] clk_next, sdi_next, le_next;
  logic                     done_next, err_next;

  assign cmdReady = (state == ST_IDLE);

  // Validate the offered command and left-align its word so the MSB sits at the top
  always_comb begin
    cmd_ok      = (cmdBitCount != '0)
               && (32'(cmdBitCount) <= 32'(DATA_WIDTH))
               && (cmdBroadcast || (32'(cmdChannel) < 32'(CHANNEL_COUNT)));
    cmd_shift   = BC_W'(DATA_WIDTH) - cmdBitCount;
    cmd_aligned = cmdData << cmd_shift;
    cmd_mask    = cmdBroadcast ? '1 : (CHANNEL_COUNT'(1) << cmdChannel);
  end

  // Next-state, datapath updates and the pin values for the coming cycle
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    bits_left_next = bits_left;
    mask_next      = mask;
    done_next      = 1'b0;
    err_next       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cmdValid) begin
          if (cmd_ok) begin
            state_next     = ST_SETUP;
            shreg_next     = cmd_aligned;
            bits_left_next = cmdBitCount;
            mask_next      = cmd_mask;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_SETUP: if (tmr_tc) state_next = ST_HIGH;
      ST_HIGH: begin
        if (tmr_tc) begin
          if (bits_left > BC_W'(1)) begin
            state_next     = ST_LOW;
            bits_left_next = bits_left - BC_W'(1);
            shreg_next     = shreg << 1;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_LOW:   if (tmr_tc) state_next = ST_HIGH;
      ST_HOLD:  if (tmr_tc) state_next = ST_LATCH;
      ST_LATCH: if (tmr_tc) state_next = ST_GAP;
      ST_GAP: begin
        if (tmr_tc) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    tmr_load  = (state_next != state);
    tmr_value = (state_next == ST_LATCH) ? TMR_W'(LE_CYCLES - 1) : TMR_W'(CLK_DIV - 1);

    clk_next = (state_next == ST_HIGH) ? mask_next : '0;
    sdi_next = '0;
    if ((state_next == ST_SETUP) || (state_next == ST_HIGH) || (state_next == ST_LOW)) begin
      sdi_next = shreg_next[DATA_WIDTH-1] ? mask_next : '0;
    end
    le_next = (state_next == ST_LATCH) ? mask_next : '0;
  end

  // State register
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register, remaining-bit counter and bus mask
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      shreg     <= '0;
      bits_left <= '0;
      mask      <= '0;
    end else begin
      shreg     <= shreg_next;
      bits_left <= bits_left_next;
      mask      <= mask_next;
    end
  end

  // Registered pins and strobes; reset drops every pin low at once
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      spiClk      <= '0;
      spiSdi      <= '0;
      spiLe       <= '0;
      doneStrobe  <= 1'b0;
      errorStrobe <= 1'b0;
    end else begin
      spiClk      <= clk_next;
      spiSdi      <= sdi_next;
      spiLe       <= le_next;
      doneStrobe  <= done_next;
      errorStrobe <= err_next;
    end
  end

  afe_spi_halfbit_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .clk       (sysClk),
    .rst       (sysReset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .tc        (tmr_tc)
  );

endmodule

// File: tb/tb_afe_spi_multi.sv
// tb/tb_afe_spi_multi.sv - self-checking bench for afe_spi_multi
module tb_afe_spi_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int sel         = 0;

  logic        c_valid, c_bc;
  logic [3:0]  c_ch;
  logic [4:0]  c_n;
  logic [23:0] c_data;
  logic [3:0]  p_ch;
  logic        p_bc;
  logic [4:0]  p_n;
  logic [23:0] p_data;

  logic       d0_ready, d0_done, d0_err;
  logic [1:0] d0_clk, d0_sdi, d0_le;
  logic       d1_ready, d1_done, d1_err;
  logic [7:0] d1_clk, d1_sdi, d1_le;
  logic       d2_ready, d2_done, d2_err;
  logic [2:0] d2_clk, d2_sdi, d2_le;

  afe_spi_multi dut0 (
    .sysClk(clk), .sysReset(rst), .cmdValid(c_valid && (sel == 0)), .cmdReady(d0_ready),
    .cmdChannel(c_ch[0:0]), .cmdBroadcast(c_bc), .cmdBitCount(c_n), .cmdData(c_data),
    .spiClk(d0_clk), .spiSdi(d0_sdi), .spiLe(d0_le), .doneStrobe(d0_done), .errorStrobe(d0_err)
  );

  afe_spi_multi #(.CHANNEL_COUNT(8), .CLK_DIV(1)) dut1 (
    .sysClk(clk), .sysReset(rst), .cmdValid(c_valid && (sel == 1)), .cmdReady(d1_ready),
    .cmdChannel(c_ch[2:0]), .cmdBroadcast(c_bc), .cmdBitCount(c_n), .cmdData(c_data),
    .spiClk(d1_clk), .spiSdi(d1_sdi), .spiLe(d1_le), .doneStrobe(d1_done), .errorStrobe(d1_err)
  );

  afe_spi_multi #(.CHANNEL_COUNT(3), .DATA_WIDTH(8), .CLK_DIV(2), .LE_CYCLES(3)) dut2 (
    .sysClk(clk), .sysReset(rst), .cmdValid(c_valid && (sel == 2)), .cmdReady(d2_ready),
    .cmdChannel(c_ch[1:0]), .cmdBroadcast(c_bc), .cmdBitCount(c_n[3:0]), .cmdData(c_data[7:0]),
    .spiClk(d2_clk), .spiSdi(d2_sdi), .spiLe(d2_le), .doneStrobe(d2_done), .errorStrobe(d2_err)
  );

  logic        m_ready, m_done, m_err;
  logic [15:0] m_clk, m_sdi, m_le;

  // Route the selected instance onto common observation signals
  always_comb begin
    m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_clk = '0; m_sdi = '0; m_le = '0;
    case (sel)
      0: begin m_ready = d0_ready; m_done = d0_done; m_err = d0_err;
               m_clk = 16'(d0_clk); m_sdi = 16'(d0_sdi); m_le = 16'(d0_le); end
      1: begin m_ready = d1_ready; m_done = d1_done; m_err = d1_err;
               m_clk = 16'(d1_clk); m_sdi = 16'(d1_sdi); m_le = 16'(d1_le); end
      default: begin m_ready = d2_ready; m_done = d2_done; m_err = d2_err;
               m_clk = 16'(d2_clk); m_sdi = 16'(d2_sdi); m_le = 16'(d2_le); end
    endcase
  end

  function automatic int t_of(input int s);
    return (s == 0) ? 5 : (s == 1) ? 1 : 2;
  endfunction
  function automatic int le_of(input int s);
    return (s == 2) ? 3 : 10;
  endfunction
  function automatic int nch_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 8 : 3;
  endfunction
  function automatic int dw_of(input int s);
    return (s == 2) ? 8 : 24;
  endfunction
  function automatic logic [15:0] model_mask(input int s, input int ch, input bit bc);
    logic [15:0] m;
    m = '0;
    if (bc) begin
      for (int b = 0; b < nch_of(s); b++) m[b] = 1'b1;
    end else if (ch < nch_of(s)) begin
      m[ch] = 1'b1;
    end
    return m;
  endfunction

  int          o_busy, o_first_rise;
  bit          o_timeout, o_ready_pre, o_done_end, o_done_early, o_err_k1, o_err_other, o_unstable;
  logic [15:0] o_act, o_sdi_k1;
  logic [31:0] o_bits [16];
  int          o_nclk [16];
  int          o_le   [16];

  task automatic capture(input bit hold);
    logic [15:0] pclk, psdi;
    int k;
    o_busy = 0; o_first_rise = -1; o_timeout = 0; o_done_end = 0; o_done_early = 0;
    o_err_k1 = 0; o_err_other = 0; o_unstable = 0; o_act = '0; o_sdi_k1 = '0;
    for (int b = 0; b < 16; b++) begin o_bits[b] = '0; o_nclk[b] = 0; o_le[b] = 0; end
    pclk = '0; psdi = '0;
    o_ready_pre = m_ready;
    @(posedge clk);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        o_err_k1 = m_err;
        o_sdi_k1 = m_sdi;
        if (hold) begin c_ch = p_ch; c_bc = p_bc; c_n = p_n; c_data = p_data; end
        else c_valid = 1'b0;
      end else if (m_err) begin
        o_err_other = 1;
      end
      o_act = o_act | m_clk | m_sdi | m_le;
      for (int b = 0; b < 16; b++) begin
        if (m_clk[b] && !pclk[b]) begin
          o_bits[b] = {o_bits[b][30:0], m_sdi[b]};
          o_nclk[b]++;
          if (o_first_rise < 0) o_first_rise = k;
        end
        if (m_le[b]) o_le[b]++;
      end
      if ((m_clk & pclk & (m_sdi ^ psdi)) != '0) o_unstable = 1;
      pclk = m_clk; psdi = m_sdi;
      if (m_ready) begin o_done_end = m_done; break; end
      if (m_done) o_done_early = 1;
      o_busy++;
      if (k > 3000) begin o_timeout = 1; break; end
    end
  endtask

  task automatic run_write(input int s, input int n, input logic [23:0] data, input int ch,
                           input bit bc, input bit hold, input bit predriven);
    bit          ok;
    int          exp_busy;
    logic [15:0] mask;
    logic [31:0] exp_bits;
    logic [15:0] idle_act;
    bit          idle_err;
    sel = s;
    if (!predriven) begin
      c_ch = 4'(ch); c_bc = bc; c_n = 5'(n); c_data = data; c_valid = 1'b1;
    end
    ok       = (n >= 1) && (n <= dw_of(s)) && (bc || (ch < nch_of(s)));
    mask     = ok ? model_mask(s, ch, bc) : 16'h0;
    exp_busy = ok ? (2 * n * t_of(s) + 2 * t_of(s) + le_of(s)) : 0;
    exp_bits = 32'(data) & ((32'd1 << n) - 32'd1);
    capture(hold);
    vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout: dut%0d n=%0d never returned to ready", s, n); end
    vectors++; if (o_ready_pre !== 1'b1) begin miscompares++; $display("FAIL ready_before_accept: got %0b expected 1", o_ready_pre); end
    vectors++; if (o_busy !== exp_busy) begin miscompares++; $display("FAIL busy_len: dut%0d n=%0d got %0d expected %0d", s, n, o_busy, exp_busy); end
    vectors++; if (o_done_end !== ok) begin miscompares++; $display("FAIL done_strobe: got %0b expected %0b", o_done_end, ok); end
    vectors++; if (o_done_early !== 1'b0) begin miscompares++; $display("FAIL done_early: got %0b expected 0", o_done_early); end
    vectors++; if (o_err_k1 !== !ok) begin miscompares++; $display("FAIL error_strobe: dut%0d n=%0d ch=%0d got %0b expected %0b", s, n, ch, o_err_k1, !ok); end
    vectors++; if (o_err_other !== 1'b0) begin miscompares++; $display("FAIL error_stray: got %0b expected 0", o_err_other); end
    vectors++; if ((o_act & ~mask) !== 16'h0) begin miscompares++; $display("FAIL unmasked_activity: got %h expected 0 (mask %h)", o_act & ~mask, mask); end
    if (ok) begin
      vectors++; if (o_first_rise !== t_of(s) + 1) begin miscompares++; $display("FAIL first_rise: got %0d expected %0d", o_first_rise, t_of(s) + 1); end
      vectors++; if (o_sdi_k1 !== (data[n-1] ? mask : 16'h0)) begin miscompares++; $display("FAIL first_sdi: got %h expected %h", o_sdi_k1, data[n-1] ? mask : 16'h0); end
      vectors++; if (o_unstable !== 1'b0) begin miscompares++; $display("FAIL sdi_changed_while_clk_high: got 1 expected 0"); end
      for (int b = 0; b < nch_of(s); b++) begin
        if (mask[b]) begin
          vectors++; if (o_nclk[b] !== n) begin miscompares++; $display("FAIL clk_count bus%0d: got %0d expected %0d", b, o_nclk[b], n); end
          vectors++; if (o_bits[b] !== exp_bits) begin miscompares++; $display("FAIL shifted_bits bus%0d: got %h expected %h", b, o_bits[b], exp_bits); end
          vectors++; if (o_le[b] !== le_of(s)) begin miscompares++; $display("FAIL le_len bus%0d: got %0d expected %0d", b, o_le[b], le_of(s)); end
        end
      end
    end else begin
      idle_act = '0; idle_err = 0;
      repeat (4) begin
        @(negedge clk);
        idle_act = idle_act | m_clk | m_sdi | m_le;
        if (m_err || !m_ready) idle_err = 1;
      end
      vectors++; if ((o_act | idle_act) !== 16'h0) begin miscompares++; $display("FAIL reject_pins: got %h expected 0", o_act | idle_act); end
      vectors++; if (idle_err !== 1'b0) begin miscompares++; $display("FAIL reject_aftermath: got %0b expected 0", idle_err); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      vectors++; if ({m_ready, m_done, m_err} !== 3'b100) begin miscompares++; $display("FAIL reset_ctrl dut%0d: got %b expected 100", s, {m_ready, m_done, m_err}); end
      vectors++; if ((m_clk | m_sdi | m_le) !== 16'h0) begin miscompares++; $display("FAIL reset_pins dut%0d: got %h expected 0", s, m_clk | m_sdi | m_le); end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sel = 0;
  endtask

  task automatic test_default_pattern;
    run_write(0, 24, 24'hA5C3F0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_broadcast;
    run_write(0, 8, 24'h000081, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reject;
    run_write(0, 0, 24'h123456, 0, 1'b0, 1'b0, 1'b0);
    run_write(0, 25, 24'h123456, 1, 1'b0, 1'b0, 1'b0);
    run_write(2, 4, 24'h00000F, 3, 1'b0, 1'b0, 1'b0);
    run_write(2, 9, 24'h0000AA, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    p_ch = 4'd1; p_bc = 1'b0; p_n = 5'd12; p_data = 24'h000C3A;
    run_write(0, 12, 24'h0005F1, 0, 1'b0, 1'b1, 1'b0);
    run_write(0, 12, 24'h000C3A, 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_write;
    bit saw_le, saw_done;
    sel = 0;
    c_ch = 4'd0; c_bc = 1'b0; c_n = 5'd24; c_data = 24'($urandom); c_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    saw_le = 0; saw_done = 0;
    repeat (49) begin
      @(negedge clk);
      if (m_le != '0) saw_le = 1;
      if (m_done) saw_done = 1;
    end
    vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL busy_before_reset: got %0b expected 0", m_ready); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ((m_clk | m_sdi | m_le) !== 16'h0) begin miscompares++; $display("FAIL async_reset_pins: got %h expected 0", m_clk | m_sdi | m_le); end
    vectors++; if (m_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_ready: got %0b expected 1", m_ready); end
    repeat (3) begin
      @(negedge clk);
      if (m_le != '0) saw_le = 1;
      if (m_done) saw_done = 1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_le != '0) saw_le = 1;
      if (m_done) saw_done = 1;
    end
    vectors++; if ({saw_le, saw_done} !== 2'b00) begin miscompares++; $display("FAIL reset_le_or_done: got %b expected 00", {saw_le, saw_done}); end
    run_write(0, 24, 24'($urandom), 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_eight_bus_fast;
    run_write(1, 1, 24'h000001, 7, 1'b0, 1'b0, 1'b0);
    run_write(1, 1, 24'h000000, 7, 1'b0, 1'b0, 1'b0);
    run_write(1, 6, 24'($urandom_range(63, 0)), 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    int s, n, ch;
    bit bc;
    for (int i = 0; i < 14; i++) begin
      s  = (i % 3 == 2) ? 2 : ((i % 3 == 1) ? 1 : 0);
      n  = $urandom_range(dw_of(s) + 2, 0);
      ch = (s == 0) ? $urandom_range(1, 0) : (s == 1) ? $urandom_range(7, 0) : $urandom_range(3, 0);
      bc = 1'($urandom_range(1, 0));
      run_write(s, n, 24'($urandom), ch, bc, 1'b0, 1'b0);
    end
  endtask

  initial begin
    c_valid = 1'b0; c_bc = 1'b0; c_ch = '0; c_n = '0; c_data = '0;
    p_ch = '0; p_bc = 1'b0; p_n = '0; p_data = '0;
    test_reset;
    test_default_pattern;
    test_broadcast;
    test_reject;
    test_back_to_back;
    test_reset_mid_write;
    test_eight_bus_fast;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
